riscv_multicycle: RTL and testbench
===================================

# riscv_multicycle

Parametrised multi-cycle RV32I-subset core, the successor to the single-cycle Fibonacci core. One shared instruction/data memory port with a ready handshake replaces the separate instruction and data memories, so wait-state memories can be attached. It executes add/sub/and/or/xor, addi/andi/ori, lw, sw, beq and jal with byte addressing. Illegal instructions trap and halt instead of producing undefined control.

## Interface
- `RESET_PC`, default 32'h0: PC loaded on reset. Must be word-aligned.
- `NREGS`, default 32: architectural register count. Only 32 or 16 (RV32E-style) is legal.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_req` out 1: memory transaction request.
- `mem_we` out 1: 1 = write, 0 = read. Valid while `mem_req` is high.
- `mem_addr` out 32: byte address. Bits [1:0] are always 0.
- `mem_wdata` out 32: store data. Valid when `mem_req` and `mem_we` are high.
- `mem_rdata` in 32: read data. Sampled in the cycle `mem_ready` is high.
- `mem_ready` in 1: transaction completes on the edge where `mem_req` and `mem_ready` are both high.
- `pc` out 32: address of the current instruction.
- `retire` out 1: one-cycle pulse when an instruction commits.
- `halt` out 1: high in TRAP.

## Operation
- States:
  - FETCH: goes to DECODE on ready.
  - DECODE:
    - R-type goes to EXE_R.
    - op-imm goes to EXE_I.
    - lw/sw go to MEMADR.
    - beq goes to BEQ.
    - jal goes to JAL.
    - any other case goes to TRAP.
  - MEMADR: lw goes to MEMRD, sw goes to MEMWR.
  - MEMRD: goes to MEMWB on ready.
  - MEMWB: goes to FETCH.
  - MEMWR: goes to FETCH on ready.
  - EXE_R and EXE_I: go to ALUWB.
  - ALUWB: goes to FETCH.
  - BEQ: goes to FETCH.
  - JAL: goes to ALUWB.
  - TRAP: absorbing; only `reset` leaves it.
- Illegal instruction means any of:
  - an unknown opcode;
  - an unsupported funct3 or funct7;
  - with NREGS=16, any rs1, rs2 or rd field of 16 or more.
- FETCH drives `mem_addr`=pc and `mem_we`=0, and latches `mem_rdata` into the instruction register on completion.
- DECODE latches rs1, rs2 and the sign-extended immediate (I/S/B/J) into A, B and IMM.
- ALU: 32-bit, wrap-around. sub only when funct7[5]=1 and op[5]=1.
- Load/store address = A + IMM with bits [1:0] forced to 0. Misaligned offsets silently round down.
- lw writes the latched `mem_rdata` to rd. sw drives `mem_wdata`=B.
- beq:
  - if A==B, pc <= pc + IMM (B-immediate);
  - otherwise pc <= pc + 4.
- jal: rd <= pc + 4 and pc <= pc + IMM (J-immediate), both on the JAL edge.
- All other instructions: pc <= pc + 4 at commit.
- x0 reads 0. Writes to x0 are discarded.
- `retire` pulses on the edge leaving MEMWB, MEMWR, ALUWB or BEQ.

## Timing
- While `reset` is high:
  - state=FETCH, pc=RESET_PC, all registers 0;
  - `mem_req`=0, `retire`=0, `halt`=0.
- In the first cycle after reset falls, `mem_req`=1 with `mem_addr`=RESET_PC.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are functions of state only and hold stable until completion. `mem_ready` low stalls indefinitely with no side effects.
- `mem_ready` while `mem_req`=0 is ignored.
- Zero-wait cycles per instruction: beq 3, R/I/sw/jal 4, lw 5. Each wait state adds 1 cycle.
- Register writeback lands on the edge leaving MEMWB or ALUWB and is visible to the next instruction's DECODE.
- Reset asserted mid-transaction aborts it: no register or pc update, and `mem_req` drops in that cycle.
- An illegal instruction enters TRAP from DECODE with no retire. `halt` rises in the next cycle. `mem_req`=0 in TRAP.

## Structure
- Package `riscv_pkg`:
  - opcode constants (OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL);
  - the `state_t` enum;
  - the ALU op encoding;
  - the immediate-type enum.
- Sub-module `riscv_mc_regfile`:
  - parametrised by NREGS;
  - 2 combinational reads, 1 synchronous write;
  - synchronous clear on `reset`;
  - x0 hardwired to 0.
- The FSM, ALU and immediate generation stay in the top module.

## Test plan
- Zero-wait program "addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sub x4,x2,x1":
  - x3=12, x4=2;
  - `retire` count 4 after 16 cycles.
- Store/load:
  - setup: x1=0x100, x2=0xCAFE;
  - "sw x2,4(x1)" gives a write to 0x104 with data 0xCAFE;
  - "lw x5,4(x1)" gives x5=0xCAFE;
  - with a 3-wait-state memory, each access stretches by exactly 3 cycles.
- Fibonacci loop using beq and jal, 10 terms stored to 0x200..0x224: memory holds 0,1,1,2,3,5,8,13,21,34.
- Write to x0 (addi x0,x0,9), then add x6,x0,x0: x6=0.
- Illegal opcode 0x0000007F at pc=0x8:
  - `halt`=1, no retire, `mem_req` stays 0;
  - after a later `reset` pulse, fetch restarts at RESET_PC.
- Reset asserted during a stalled lw (`mem_ready`=0): rd unchanged (0), pc=RESET_PC, `mem_req`=0 in the reset cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcodes, FSM state encoding, ALU op encoding and
// immediate formats for the multi-cycle RV32I-subset core.
package riscv_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXE_R, EXE_I, ALUWB, BEQ, JAL, TRAP
  } state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR} alu_op_t;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_t;

  // Sign-extended immediate; takes IR[31:7] since the opcode bits never
  // contribute to any immediate.
  function automatic logic [31:0] imm_gen(input logic [31:7] instr, input imm_t sel);
    logic [31:0] v;
    case (sel)
      IMM_I:   v = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default: v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endcase
    return v;
  endfunction

  // 32-bit wrap-around ALU.
  function automatic logic [31:0] alu(input logic [31:0] x, input logic [31:0] y,
                                      input alu_op_t op);
    logic [31:0] r;
    case (op)
      ALU_SUB: r = x - y;
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_XOR: r = x ^ y;
      default: r = x + y;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_mc_regfile.sv
// riscv_mc_regfile: NREGS x 32 register file, two combinational read ports,
// one synchronous write port, cleared by synchronous reset, x0 reads zero.
module riscv_mc_regfile
#(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  localparam int AW = $clog2(NREGS);

  logic [31:0] regs [NREGS];

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1[AW-1:0]];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2[AW-1:0]];

  // Clear everything on reset; writes aimed at x0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/riscv_multicycle.sv
// riscv_multicycle: multi-cycle RV32I-subset core (add/sub/and/or/xor,
// addi/andi/ori, lw, sw, beq, jal) on one shared memory port with a ready
// handshake. Illegal instructions park the core in TRAP until reset.
module riscv_multicycle
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halt,
  output logic [3:0]  dbg_state
);

  // The two low bits are dropped so a misconfigured RESET_PC still fetches
  // from an aligned word.
  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  state_t      state, state_next;
  logic [31:0] ir, a, b, imm, alu_out, mdr;
  logic [31:0] rf_rd1, rf_rd2, rf_wdata;
  logic        rf_we;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  logic    illegal, use_rs1, use_rs2, use_rd;
  imm_t    imm_sel;
  alu_op_t alu_op;

  // Decode the IR: legality, immediate format and ALU operation.
  always_comb begin
    illegal = 1'b0;
    imm_sel = IMM_I;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      OP_R: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        illegal = !(funct3 inside {3'b000, 3'b100, 3'b110, 3'b111}) ||
                  !((funct7 == 7'b0000000) || ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
      end
      OP_I: begin
        use_rs1 = 1'b1; use_rd = 1'b1;
        illegal = !(funct3 inside {3'b000, 3'b110, 3'b111});
      end
      OP_LW: begin
        use_rs1 = 1'b1; use_rd = 1'b1;
        illegal = (funct3 != 3'b010);
      end
      OP_SW: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; imm_sel = IMM_S;
        illegal = (funct3 != 3'b010);
      end
      OP_BEQ: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; imm_sel = IMM_B;
        illegal = (funct3 != 3'b000);
      end
      OP_JAL: begin
        use_rd = 1'b1; imm_sel = IMM_J;
      end
      default: illegal = 1'b1;
    endcase
    // RV32E-style build: register fields that the format uses must be < 16.
    if (NREGS == 16)
      illegal = illegal || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4]);
    case (funct3)
      3'b111:  alu_op = ALU_AND;
      3'b110:  alu_op = ALU_OR;
      3'b100:  alu_op = ALU_XOR;
      default: alu_op = (funct7[5] && opcode[5]) ? ALU_SUB : ALU_ADD;
    endcase
  end

  riscv_mc_regfile #(.NREGS(NREGS)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (rf_wdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Next state and state-decoded outputs. Memory handshake: mem_req, mem_we,
  // mem_addr and mem_wdata depend only on state and hold until the edge where
  // mem_req && mem_ready, which completes the transaction; mem_ready with no
  // request is ignored. Reset masks every strobe in the same cycle.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = alu_out;
    retire     = 1'b0;
    rf_we      = 1'b0;
    rf_wdata   = alu_out;
    case (state)
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        if (illegal) state_next = TRAP;
        else begin
          case (opcode)
            OP_R:          state_next = EXE_R;
            OP_I:          state_next = EXE_I;
            OP_LW, OP_SW:  state_next = MEMADR;
            OP_BEQ:        state_next = BEQ;
            OP_JAL:        state_next = JAL;
            default:       state_next = TRAP;
          endcase
        end
      end
      MEMADR: state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD: begin
        mem_req = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        rf_we      = 1'b1;
        rf_wdata   = mdr;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      EXE_R, EXE_I: state_next = ALUWB;
      ALUWB: begin
        // jal already wrote its link register on the JAL edge.
        rf_we      = (opcode != OP_JAL);
        retire     = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        retire     = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        rf_we      = 1'b1;
        rf_wdata   = pc + 32'd4;
        state_next = ALUWB;
      end
      TRAP:    state_next = TRAP;
      default: state_next = FETCH;
    endcase
    if (reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      retire  = 1'b0;
      rf_we   = 1'b0;
    end
  end

  assign mem_wdata = b;
  assign halt      = (state == TRAP) && !reset;
  assign dbg_state = state;

  // Datapath registers: IR, operand latches, ALU result, memory data and pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC_W;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        FETCH:  if (mem_ready) ir <= mem_rdata;
        DECODE: begin
          a   <= rf_rd1;
          b   <= rf_rd2;
          imm <= imm_gen(ir[31:7], imm_sel);
        end
        MEMADR: alu_out <= (a + imm) & ~32'd3;
        MEMRD:  if (mem_ready) mdr <= mem_rdata;
        MEMWB:  pc <= pc + 32'd4;
        MEMWR:  if (mem_ready) pc <= pc + 32'd4;
        EXE_R:  alu_out <= alu(a, b, alu_op);
        EXE_I:  alu_out <= alu(a, imm, alu_op);
        ALUWB:  if (opcode != OP_JAL) pc <= pc + 32'd4;
        BEQ:    pc <= (a == b) ? pc + imm : pc + 32'd4;
        JAL:    pc <= pc + imm;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_multicycle.sv
// tb_riscv_multicycle: directed programs on a word memory model with
// programmable wait states; stores are checked by a scoreboard monitor.
module tb_riscv_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [3:0]  dbg_state;

  logic [31:0] mem [0:255];
  int          nwait = 0;
  logic        stall = 1'b0;
  int          wcnt = 0;

  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          retire_cnt = 0;
  int          cyc = 0;

  localparam logic [31:0] ILLEGAL = 32'h0000007F;

  riscv_multicycle dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .retire    (retire),
    .halt      (halt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  assign mem_ready = mem_req && !stall && (wcnt == nwait);
  assign mem_rdata = mem[mem_addr[9:2]];

  initial forever begin
    @(posedge clk);
    if (mem_req && mem_we && mem_ready) mem[mem_addr[9:2]] = mem_wdata;
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
  end

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    logic [63:0] exp;
    @(negedge clk);
    if (!reset && retire) retire_cnt++;
    if (mem_req) begin
      n_checks++;
      if ((mem_addr[1:0] != 2'b00) || (mem_addr >= 32'h400)) begin
        n_fail++;
        $display("FAIL mem_addr_range: got %h required aligned below 400", mem_addr);
      end
    end
    if (mem_req && mem_we && mem_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL store_unexpected: got addr=%h data=%h required no store", mem_addr, mem_wdata);
      end else begin
        exp = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== exp) begin
          n_fail++;
          $display("FAIL store: got addr=%h data=%h required addr=%h data=%h",
                   mem_addr, mem_wdata, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] i_type(input int imm, input int rs1, input int f3,
                                         input int rd, input int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] r_type(input int f7, input int rs2, input int rs1,
                                         input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return i_type(imm, rs1, 0, rd, 'h13);
  endfunction
  function automatic logic [31:0] lw(input int rd, input int off, input int rs1);
    return i_type(off, rs1, 2, rd, 'h03);
  endfunction
  function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
    return r_type(0, rs2, rs1, 0, rd);
  endfunction
  function automatic logic [31:0] sub(input int rd, input int rs1, input int rs2);
    return r_type('h20, rs2, rs1, 0, rd);
  endfunction
  function automatic logic [31:0] sw(input int rs2, input int off, input int rs1);
    return {off[11:5], rs2[4:0], rs1[4:0], 3'b010, off[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] beq(input int rs1, input int rs2, input int off);
    return {off[12], off[10:5], rs2[4:0], rs1[4:0], 3'b000, off[4:1], off[11], 7'h63};
  endfunction
  function automatic logic [31:0] jal(input int rd, input int off);
    return {off[20], off[10:1], off[11], off[19:12], rd[4:0], 7'h6F};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic put(input int addr, input logic [31:0] word);
    mem[addr[9:2]] = word;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  task automatic expect_store(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic start_test(input int waits);
    @(posedge clk);
    #1 reset = 1'b1;
    stall = 1'b0;
    nwait = waits;
    clear_mem();
  endtask

  // Holds reset for two edges, checks the reset state, then releases reset
  // just after an edge so that the next cycle is cycle 1.
  task automatic release_reset();
    @(posedge clk);
    @(negedge clk);
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_retire", {31'd0, retire}, 32'd0);
    check("reset_halt", {31'd0, halt}, 32'd0);
    check("reset_pc", pc, 32'h0);
    check("reset_state", {28'd0, dbg_state}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    retire_cnt = 0;
    cyc = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_halt(input int limit);
    while (!halt && (cyc < limit)) tick();
    check("halt_reached", {31'd0, halt}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Arithmetic program, zero wait states.
    start_test(0);
    put(0,  addi(1, 0, 5));
    put(4,  addi(2, 0, 7));
    put(8,  add(3, 1, 2));
    put(12, sub(4, 2, 1));
    put(16, sw(3, 'h300, 0));
    put(20, sw(4, 'h304, 0));
    put(24, ILLEGAL);
    expect_store(32'h300, 32'd12);
    expect_store(32'h304, 32'd2);
    release_reset();
    tick();
    check("first_fetch_req", {31'd0, mem_req}, 32'd1);
    check("first_fetch_addr", mem_addr, 32'h0);
    check("first_fetch_we", {31'd0, mem_we}, 32'd0);
    repeat (15) tick();
    #1 check("retire_after_16", retire_cnt, 32'd4);
    wait_halt(200);
    check("arith_halt_cycle", cyc, 32'd27);
    check("arith_retires", retire_cnt, 32'd6);

    // Store/load, zero wait states then three wait states.
    for (int w = 0; w <= 3; w += 3) begin
      start_test(w);
      put(0,  addi(1, 0, 'h100));
      put(4,  lw(2, 'h3F0, 0));
      put(8,  sw(2, 4, 1));
      put(12, lw(5, 4, 1));
      put(16, sw(5, 'h308, 0));
      put(20, ILLEGAL);
      put('h3F0, 32'h0000CAFE);
      expect_store(32'h104, 32'h0000CAFE);
      expect_store(32'h308, 32'h0000CAFE);
      release_reset();
      wait_halt(300);
      check(w == 0 ? "ldst_cycles_w0" : "ldst_cycles_w3", cyc, (w == 0) ? 32'd25 : 32'd55);
      check("ldst_retires", retire_cnt, 32'd5);
    end

    // Fibonacci loop with beq/jal, one wait state.
    start_test(1);
    put(0,  addi(1, 0, 0));
    put(4,  addi(2, 0, 1));
    put(8,  addi(3, 0, 'h200));
    put(12, addi(4, 0, 'h228));
    put(16, beq(3, 4, 28));
    put(20, sw(1, 0, 3));
    put(24, add(5, 1, 2));
    put(28, addi(1, 2, 0));
    put(32, addi(2, 5, 0));
    put(36, addi(3, 3, 4));
    put(40, jal(0, -24));
    put(44, ILLEGAL);
    expect_store(32'h200, 32'd0);
    expect_store(32'h204, 32'd1);
    expect_store(32'h208, 32'd1);
    expect_store(32'h20C, 32'd2);
    expect_store(32'h210, 32'd3);
    expect_store(32'h214, 32'd5);
    expect_store(32'h218, 32'd8);
    expect_store(32'h21C, 32'd13);
    expect_store(32'h220, 32'd21);
    expect_store(32'h224, 32'd34);
    release_reset();
    wait_halt(3000);
    check("fib_halt_pc", pc, 32'd44);
    check("fib_store_queue", exp_q.size(), 32'd0);

    // x0 writes are discarded; jal links pc+4.
    start_test(0);
    put(0,  addi(0, 0, 9));
    put(4,  add(6, 0, 0));
    put(8,  sw(6, 'h30C, 0));
    put(12, jal(7, 8));
    put(16, ILLEGAL);
    put(20, sw(7, 'h310, 0));
    put(24, ILLEGAL);
    expect_store(32'h30C, 32'd0);
    expect_store(32'h310, 32'd16);
    release_reset();
    wait_halt(200);
    check("x0_jal_halt_cycle", cyc, 32'd23);
    check("x0_jal_retires", retire_cnt, 32'd5);

    // Illegal opcode at pc=8, then a reset pulse restarts fetch.
    start_test(0);
    put(0, addi(1, 0, 1));
    put(4, addi(2, 0, 2));
    put(8, ILLEGAL);
    release_reset();
    wait_halt(100);
    check("trap_halt_cycle", cyc, 32'd11);
    repeat (4) begin
      tick();
      check("trap_mem_req", {31'd0, mem_req}, 32'd0);
      check("trap_retire", {31'd0, retire}, 32'd0);
    end
    check("trap_pc", pc, 32'd8);
    check("trap_retires", retire_cnt, 32'd2);
    check("trap_state", {28'd0, dbg_state}, 32'd11);
    @(posedge clk);
    #1 reset = 1'b1;
    release_reset();
    tick();
    check("restart_req", {31'd0, mem_req}, 32'd1);
    check("restart_addr", mem_addr, 32'h0);
    check("restart_halt", {31'd0, halt}, 32'd0);

    // Reset during a stalled lw.
    start_test(0);
    put(0, addi(1, 0, 1));
    put(4, lw(5, 'h3F0, 0));
    put('h3F0, 32'h0000CAFE);
    release_reset();
    repeat (5) @(posedge clk);
    #1 stall = 1'b1;
    repeat (4) @(negedge clk);
    check("stall_req", {31'd0, mem_req}, 32'd1);
    check("stall_addr", mem_addr, 32'h3F0);
    check("stall_we", {31'd0, mem_we}, 32'd0);
    check("stall_pc", pc, 32'd4);
    check("stall_retires", retire_cnt, 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_mem_req", {31'd0, mem_req}, 32'd0);
    check("abort_retire", {31'd0, retire}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("abort_pc", pc, 32'h0);
    stall = 1'b0;
    clear_mem();
    put(0, sw(5, 'h314, 0));
    put(4, ILLEGAL);
    expect_store(32'h314, 32'd0);
    release_reset();
    wait_halt(100);
    check("abort_rerun_cycle", cyc, 32'd7);

    repeat (2) tick();
    check("final_store_queue", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Backstop so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
